// File: rtl/vproc_fifo_mailbox_if.sv
// rtl/vproc_fifo_mailbox_if.sv - VProc bus, interrupt and TX/RX word streams of the mailbox
interface vproc_fifo_mailbox_if;
  logic        CS;
  logic [1:0]  A;
  logic        WE;
  logic        RD;
  logic [31:0] DI;
  logic [31:0] DO;
  logic        WRAck;
  logic        RDAck;
  logic        Irq;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [31:0] rx_data;
  logic        rx_ready;

  modport master (
    output CS, A, WE, RD, DI, tx_ready, rx_valid, rx_data,
    input  DO, WRAck, RDAck, Irq, tx_valid, tx_data, rx_ready
  );

  modport slave (
    input  CS, A, WE, RD, DI, tx_ready, rx_valid, rx_data,
    output DO, WRAck, RDAck, Irq, tx_valid, tx_data, rx_ready
  );
endinterface

// File: rtl/vproc_fifo_mailbox.sv
// rtl/vproc_fifo_mailbox.sv - register-mapped mailbox on the VProc memory bus
// Bus writes to DATA feed the TX FIFO; bus reads of DATA drain the RX FIFO.
module vproc_fifo_mailbox #(
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                   clk,
  input  logic                   nreset,
  vproc_fifo_mailbox_if.slave    bus
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;
  localparam int unsigned PW    = DEPTH_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  a_q, a_d;
  logic [31:0] di_q, di_d;
  logic        access;

  logic [31:0] tx_mem_q [DEPTH];
  logic [31:0] rx_mem_q [DEPTH];
  logic [PW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic [LW-1:0] tx_level_q, tx_level_d, rx_level_q, rx_level_d;
  logic        tx_ovf_q, rx_unf_q;
  logic [1:0]  ctrl_q;
  logic [31:0] scratch_q;
  logic [31:0] do_q;
  logic        irq_q;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic host_wr, host_rd;
  logic tx_push, tx_pop, tx_ovf_set, rx_push, rx_pop, rx_unf_set;
  logic [31:0] status, rdata;

  // access marks the edge entering ACK; *_d carry the captured op on that edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    a_d     = a_q;
    di_d    = di_q;
    access  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.CS && (bus.WE || bus.RD)) begin
          we_d = bus.WE;
          a_d  = bus.A;
          di_d = bus.DI;
          if (WAIT_STATES == 0) begin
            state_d = S_ACK;
            access  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_ACK;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_full  = (tx_level_q == LW'(DEPTH));
  assign tx_empty = (tx_level_q == '0);
  assign rx_full  = (rx_level_q == LW'(DEPTH));
  assign rx_empty = (rx_level_q == '0);

  assign host_wr    = access & we_d;
  assign host_rd    = access & ~we_d;
  assign tx_push    = host_wr & (a_d == 2'd0) & ~tx_full;
  assign tx_ovf_set = host_wr & (a_d == 2'd0) & tx_full;
  assign tx_pop     = ~tx_empty & bus.tx_ready;
  assign rx_push    = bus.rx_valid & ~rx_full;
  assign rx_pop     = host_rd & (a_d == 2'd0) & ~rx_empty;
  assign rx_unf_set = host_rd & (a_d == 2'd0) & rx_empty;

  assign tx_level_d = tx_level_q + LW'(tx_push) - LW'(tx_pop);
  assign rx_level_d = rx_level_q + LW'(rx_push) - LW'(rx_pop);

  assign status = {8'd0, 8'(rx_level_q), 8'(tx_level_q), 2'b00,
                   rx_unf_q, tx_ovf_q, rx_empty, rx_full, tx_empty, tx_full};

  always_comb begin
    rdata = 32'd0;
    case (a_d)
      2'd0:    rdata = rx_empty ? 32'd0 : rx_mem_q[rx_rd_q];
      2'd1:    rdata = status;
      2'd2:    rdata = {30'd0, ctrl_q};
      default: rdata = scratch_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      a_q        <= 2'd0;
      di_q       <= 32'd0;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      tx_level_q <= '0;
      rx_level_q <= '0;
      tx_ovf_q   <= 1'b0;
      rx_unf_q   <= 1'b0;
      ctrl_q     <= 2'd0;
      scratch_q  <= 32'd0;
      do_q       <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      a_q        <= a_d;
      di_q       <= di_d;
      tx_level_q <= tx_level_d;
      rx_level_q <= rx_level_d;
      if (tx_push) tx_wr_q <= tx_wr_q + PW'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + PW'(1);
      if (rx_push) rx_wr_q <= rx_wr_q + PW'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + PW'(1);
      tx_ovf_q <= (tx_ovf_q & ~(host_wr & (a_d == 2'd1) & di_d[4])) | tx_ovf_set;
      rx_unf_q <= (rx_unf_q & ~(host_wr & (a_d == 2'd1) & di_d[5])) | rx_unf_set;
      if (host_wr && a_d == 2'd2) ctrl_q    <= di_d[1:0];
      if (host_wr && a_d == 2'd3) scratch_q <= di_d;
      if (host_rd) do_q <= rdata;
      irq_q <= (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_empty);
    end
  end

  always_ff @(posedge clk) begin
    if (nreset && tx_push) tx_mem_q[tx_wr_q] <= di_d;
    if (nreset && rx_push) rx_mem_q[rx_wr_q] <= bus.rx_data;
  end

  assign bus.DO       = do_q;
  assign bus.WRAck    = (state_q == S_ACK) & we_q;
  assign bus.RDAck    = (state_q == S_ACK) & ~we_q;
  assign bus.Irq      = irq_q;
  assign bus.tx_valid = ~tx_empty;
  assign bus.tx_data  = tx_mem_q[tx_rd_q];
  assign bus.rx_ready = ~rx_full;
endmodule

// File: tb/tb_vproc_fifo_mailbox.sv
// tb/tb_vproc_fifo_mailbox.sv - self-checking bench for vproc_fifo_mailbox
// Instance 0 uses one wait state, instance 1 none; stream words are tracked in queues.
module tb_vproc_fifo_mailbox;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [31:0] txq[$];
  logic [31:0] rxq[$];

  vproc_fifo_mailbox_if if0();
  vproc_fifo_mailbox_if if1();

  vproc_fifo_mailbox #(.DEPTH_LOG2(4), .WAIT_STATES(1)) u0 (.clk(clk), .nreset(nreset), .bus(if0));
  vproc_fifo_mailbox #(.DEPTH_LOG2(4), .WAIT_STATES(0)) u1 (.clk(clk), .nreset(nreset), .bus(if1));

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  a;
    logic [31:0] di;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic cs, input logic we, input logic rd,
                       input logic [1:0] a, input logic [31:0] di);
    if (sel == 0) begin
      if0.CS = cs; if0.WE = we; if0.RD = rd; if0.A = a; if0.DI = di;
    end else begin
      if1.CS = cs; if1.WE = we; if1.RD = rd; if1.A = a; if1.DI = di;
    end
  endtask

  function automatic logic get_ack(input int sel, input logic we);
    if (sel == 0) return we ? if0.WRAck : if0.RDAck;
    return we ? if1.WRAck : if1.RDAck;
  endfunction

  function automatic logic [31:0] get_do(input int sel);
    return (sel == 0) ? if0.DO : if1.DO;
  endfunction

  task automatic bus_op(input int sel, input logic we, input logic [1:0] a, input logic [31:0] di,
                        output logic [31:0] rdata, output int lat);
    logic got;
    @(posedge clk); #1;
    drive(sel, 1'b1, we, !we, a, di);
    @(posedge clk);
    got = 1'b0; lat = 0; rdata = 32'd0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (get_ack(sel, we)) begin
        got = 1'b1; lat = i; rdata = get_do(sel);
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL ack_timeout: sel=%0d a=%0d no ack within 20 cycles", sel, a);
    end
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic wr(input int sel, input logic [1:0] a, input logic [31:0] di, input int exp_lat);
    logic [31:0] r; int lat;
    bus_op(sel, 1'b1, a, di, r, lat);
    check("wr_latency", 32'(lat), 32'(exp_lat));
  endtask

  task automatic rd(input int sel, input string nm, input logic [1:0] a, input logic [31:0] exp, input int exp_lat);
    logic [31:0] r; int lat;
    bus_op(sel, 1'b0, a, 32'd0, r, lat);
    check(nm, r, exp);
    check("rd_latency", 32'(lat), 32'(exp_lat));
  endtask

  task automatic rx_push(input logic [31:0] w);
    @(posedge clk); #1;
    check("rx_ready", 32'(if0.rx_ready), 32'd1);
    if0.rx_valid = 1'b1; if0.rx_data = w;
    rxq.push_back(w);
    @(posedge clk); #1;
    if0.rx_valid = 1'b0;
  endtask

  // consumer side of the TX stream
  always @(negedge clk) begin
    if (nreset && if0.tx_valid && if0.tx_ready) begin
      if (txq.size() == 0) begin
        total++; bad++;
        $display("FAIL tx_unexpected: got %h expected no word", if0.tx_data);
      end else begin
        check("tx_order", if0.tx_data, txq.pop_front());
      end
    end
  end

  initial begin
    int acks;
    logic [31:0] r;
    int lat;

    vecs.push_back('{"scratch_wr",  1'b1, 2'd3, 32'hDEADBEEF, 32'd0,        2});
    vecs.push_back('{"scratch_rd",  1'b0, 2'd3, 32'd0,        32'hDEADBEEF, 2});
    vecs.push_back('{"ctrl_wr_all", 1'b1, 2'd2, 32'hFFFFFFFF, 32'd0,        2});
    vecs.push_back('{"ctrl_rd_3",   1'b0, 2'd2, 32'd0,        32'h3,        2});
    vecs.push_back('{"ctrl_wr_0",   1'b1, 2'd2, 32'd0,        32'd0,        2});
    vecs.push_back('{"ctrl_rd_0",   1'b0, 2'd2, 32'd0,        32'd0,        2});
    vecs.push_back('{"status_idle", 1'b0, 2'd1, 32'd0,        32'h0000000A, 2});

    drive(0, 0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0, 0);
    if0.tx_ready = 1'b0; if0.rx_valid = 1'b0; if0.rx_data = 32'd0;
    if1.tx_ready = 1'b1; if1.rx_valid = 1'b0; if1.rx_data = 32'd0;
    repeat (3) @(posedge clk);
    #1 nreset = 1'b1;
    @(negedge clk);
    check("rst_do",       if0.DO, 32'd0);
    check("rst_wrack",    32'(if0.WRAck), 32'd0);
    check("rst_rdack",    32'(if0.RDAck), 32'd0);
    check("rst_irq",      32'(if0.Irq), 32'd0);
    check("rst_tx_valid", 32'(if0.tx_valid), 32'd0);
    check("rst_rx_ready", 32'(if0.rx_ready), 32'd1);
    check("rst_rx_ready1", 32'(if1.rx_ready), 32'd1);

    // register vectors
    foreach (vecs[i]) begin
      bus_op(0, vecs[i].we, vecs[i].a, vecs[i].di, r, lat);
      if (!vecs[i].we) check(vecs[i].name, r, vecs[i].exp);
      check("vec_latency", 32'(lat), 32'(vecs[i].lat));
    end

    // TX fill past full, then drain
    for (int i = 0; i < 17; i++) begin
      if (i < 16) txq.push_back(32'h100 + 32'(i));
      wr(0, 2'd0, 32'h100 + 32'(i), 2);
    end
    rd(0, "status_tx_full", 2'd1, 32'h00001019, 2);
    @(posedge clk); #1 if0.tx_ready = 1'b1;
    for (int i = 0; i < 100 && txq.size() != 0; i++) @(posedge clk);
    check("tx_drained", 32'(txq.size()), 32'd0);
    @(negedge clk);
    check("tx_valid_empty", 32'(if0.tx_valid), 32'd0);
    rd(0, "status_tx_ovf", 2'd1, 32'h0000001A, 2);
    wr(0, 2'd1, 32'h10, 2);
    rd(0, "status_ovf_clr", 2'd1, 32'h0000000A, 2);

    // RX reads including underflow
    rx_push(32'hA1); rx_push(32'hB2); rx_push(32'hC3);
    rd(0, "status_rx3", 2'd1, 32'h00030002, 2);
    for (int i = 0; i < 3; i++) rd(0, "rx_word", 2'd0, rxq.pop_front(), 2);
    rd(0, "rx_empty_zero", 2'd0, 32'd0, 2);
    rd(0, "status_unf", 2'd1, 32'h0000002A, 2);
    wr(0, 2'd1, 32'h20, 2);
    rd(0, "status_unf_clr", 2'd1, 32'h0000000A, 2);

    // interrupt
    wr(0, 2'd2, 32'd1, 2);
    repeat (2) @(negedge clk);
    check("irq_rx_empty", 32'(if0.Irq), 32'd0);
    rx_push(32'h5A5A);
    @(negedge clk);
    check("irq_lag", 32'(if0.Irq), 32'd0);
    @(negedge clk);
    check("irq_rx_nonempty", 32'(if0.Irq), 32'd1);
    rd(0, "irq_pop", 2'd0, rxq.pop_front(), 2);
    repeat (2) @(negedge clk);
    check("irq_after_pop", 32'(if0.Irq), 32'd0);
    wr(0, 2'd2, 32'd2, 2);
    repeat (2) @(negedge clk);
    check("irq_tx_empty", 32'(if0.Irq), 32'd1);

    // reset during WAIT of a DATA write
    rd(0, "pre_rst_scratch", 2'd3, 32'hDEADBEEF, 2);
    @(posedge clk); #1 if0.tx_ready = 1'b0;
    txq.push_back(32'h55);
    wr(0, 2'd0, 32'h55, 2);
    @(posedge clk); #1 drive(0, 1, 1, 0, 2'd0, 32'h77);
    @(posedge clk); #1 nreset = 1'b0; drive(0, 0, 0, 0, 2'd0, 32'd0);
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (if0.WRAck) acks++;
    end
    check("rst_abort_noack", 32'(acks), 32'd0);
    check("rst2_do",       if0.DO, 32'd0);
    check("rst2_irq",      32'(if0.Irq), 32'd0);
    check("rst2_tx_valid", 32'(if0.tx_valid), 32'd0);
    check("rst2_rx_ready", 32'(if0.rx_ready), 32'd1);
    txq.delete(); rxq.delete();
    @(posedge clk); #1 nreset = 1'b1; if0.tx_ready = 1'b1;
    rd(0, "rst2_status", 2'd1, 32'h0000000A, 2);
    rd(0, "rst2_ctrl",   2'd2, 32'd0, 2);
    rd(0, "rst2_scratch", 2'd3, 32'd0, 2);

    // zero wait states: held strobe gives an ack every second cycle
    @(posedge clk); #1 drive(1, 1, 1, 0, 2'd3, 32'hCAFE0001);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("b2b_wrack", 32'(if1.WRAck), 32'(k % 2));
    end
    @(posedge clk); #1 drive(1, 0, 1, 0, 2'd3, 32'h12345678);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (if1.WRAck) acks++;
    end
    check("cs_low_noack", 32'(acks), 32'd0);
    @(posedge clk); #1 drive(1, 0, 0, 0, 2'd0, 32'd0);
    rd(1, "ws0_scratch", 2'd3, 32'hCAFE0001, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
